// File: rtl/pulse_pkg.sv
// Shared types for the pulse-instruction issuer: word opcodes, FSM states,
// payload widths and the descriptor record held in the FIFO.
package pulse_pkg;
  localparam int PAYLOAD_W = 28;
  localparam int PHASE_W   = 16;
  localparam int AMP_W     = 16;
  localparam int TLEN_W    = 24;

  typedef enum logic [3:0] {
    OP_FREQ   = 4'h1,
    OP_PHASE  = 4'h2,
    OP_AMP    = 4'h3,
    OP_TSTART = 4'h4,
    OP_TLEN   = 4'h5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FREQ,
    ST_PHASE,
    ST_AMP,
    ST_TSTART,
    ST_TLEN
  } state_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] freq;
    logic [PHASE_W-1:0]   phase;
    logic [AMP_W-1:0]     amp;
    logic [PAYLOAD_W-1:0] tstart;
    logic [TLEN_W-1:0]    tlen;
  } pulse_desc_t;

  function automatic logic [31:0] make_word(opcode_e op, logic [PAYLOAD_W-1:0] payload);
    return {op, payload};
  endfunction
endpackage

// File: rtl/pulse_desc_fifo.sv
// First-word-fall-through descriptor FIFO; head stays put until popped.
// Flush wins over a push or pop in the same cycle.
module pulse_desc_fifo
  import pulse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  pulse_desc_t                  din,
  output pulse_desc_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  pulse_desc_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/pulse_inst_issuer.sv
// Serializes queued pulse descriptors into FREQ/PHASE/AMP/TSTART/TLEN words.
// Define PULSE_ISSUER_DEDUP_EN to skip FREQ/PHASE/AMP words equal to the last sent value.
module pulse_inst_issuer
  import pulse_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TIME_W = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         desc_valid,
  output logic                         desc_ready,
  input  logic [PAYLOAD_W-1:0]         desc_freq,
  input  logic [PHASE_W-1:0]           desc_phase,
  input  logic [AMP_W-1:0]             desc_amp,
  input  logic [TIME_W-1:0]            desc_tstart,
  input  logic [TLEN_W-1:0]            desc_tlen,
  input  logic                         flush,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [31:0]                  inst_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e      state_q, state_d, eff_state;
  pulse_desc_t push_desc, head;
  logic        fifo_full, fifo_empty, pop;
  logic [31:0] word;

  assign push_desc = '{freq: desc_freq, phase: desc_phase, amp: desc_amp,
                       tstart: PAYLOAD_W'(desc_tstart), tlen: desc_tlen};

  pulse_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (desc_valid),
    .pop   (pop),
    .flush (flush),
    .din   (push_desc),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef PULSE_ISSUER_DEDUP_EN
  logic [PAYLOAD_W-1:0] last_freq_q, last_freq_d;
  logic [PHASE_W-1:0]   last_phase_q, last_phase_d;
  logic [AMP_W-1:0]     last_amp_q, last_amp_d;
  logic [2:0]           last_vld_q, last_vld_d;  // {amp, phase, freq}

  // state_q holds the nominal position; redundant words fall through here in zero cycles
  always_comb begin
    eff_state = state_q;
    if (eff_state == ST_FREQ && last_vld_q[0] && last_freq_q == head.freq)
      eff_state = ST_PHASE;
    if (eff_state == ST_PHASE && last_vld_q[1] && last_phase_q == head.phase)
      eff_state = ST_AMP;
    if (eff_state == ST_AMP && last_vld_q[2] && last_amp_q == head.amp)
      eff_state = ST_TSTART;
  end

  always_comb begin
    last_freq_d  = last_freq_q;
    last_phase_d = last_phase_q;
    last_amp_d   = last_amp_q;
    last_vld_d   = last_vld_q;
    if (flush) begin
      last_vld_d = '0;
    end else if (inst_ready) begin
      case (eff_state)
        ST_FREQ:  begin last_freq_d  = head.freq;  last_vld_d[0] = 1'b1; end
        ST_PHASE: begin last_phase_d = head.phase; last_vld_d[1] = 1'b1; end
        ST_AMP:   begin last_amp_d   = head.amp;   last_vld_d[2] = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_freq_q  <= '0;
      last_phase_q <= '0;
      last_amp_q   <= '0;
      last_vld_q   <= '0;
    end else begin
      last_freq_q  <= last_freq_d;
      last_phase_q <= last_phase_d;
      last_amp_q   <= last_amp_d;
      last_vld_q   <= last_vld_d;
    end
  end
`else
  assign eff_state = state_q;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    word    = '0;
    case (eff_state)
      ST_IDLE: if (!fifo_empty) state_d = ST_FREQ;
      ST_FREQ: begin
        word = make_word(OP_FREQ, head.freq);
        if (inst_ready) state_d = ST_PHASE;
      end
      ST_PHASE: begin
        word = make_word(OP_PHASE, PAYLOAD_W'(head.phase));
        if (inst_ready) state_d = ST_AMP;
      end
      ST_AMP: begin
        word = make_word(OP_AMP, PAYLOAD_W'(head.amp));
        if (inst_ready) state_d = ST_TSTART;
      end
      ST_TSTART: begin
        word = make_word(OP_TSTART, head.tstart);
        if (inst_ready) state_d = ST_TLEN;
      end
      ST_TLEN: begin
        word = make_word(OP_TLEN, PAYLOAD_W'(head.tlen));
        if (inst_ready) begin
          pop = 1'b1;
          // a push landing with this pop keeps the FIFO non-empty, so no bubble
          state_d = (fifo_count > CNT_W'(1) || desc_valid) ? ST_FREQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign inst_valid = (state_q != ST_IDLE);
  assign inst_data  = word;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);
  assign desc_ready = !fifo_full;
endmodule

// File: tb/tb_pulse_inst_issuer.sv
// Scoreboard bench for pulse_inst_issuer: accepted descriptors expand into expected
// word lists; a negedge monitor pops and compares every accepted instruction word.
`timescale 1ns/1ps
module tb_pulse_inst_issuer;
  localparam int DEPTH  = 4;
  localparam int TIME_W = 28;
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef PULSE_ISSUER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              desc_valid = 1'b0;
  logic              flush = 1'b0;
  logic              inst_ready = 1'b0;
  logic [27:0]       desc_freq = '0;
  logic [15:0]       desc_phase = '0;
  logic [15:0]       desc_amp = '0;
  logic [TIME_W-1:0] desc_tstart = '0;
  logic [23:0]       desc_tlen = '0;
  logic              desc_ready, inst_valid, busy;
  logic [31:0]       inst_data;
  logic [CNT_W-1:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;
  int hs_count = 0;
  logic [31:0] exp_q[$];
  logic        m_vld_f = 1'b0, m_vld_p = 1'b0, m_vld_a = 1'b0;
  logic [27:0] m_freq = '0;
  logic [15:0] m_phase = '0, m_amp = '0;
  bit          drv_done;

  always #5 clk = ~clk;

  pulse_inst_issuer #(.DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_freq(desc_freq), .desc_phase(desc_phase), .desc_amp(desc_amp),
    .desc_tstart(desc_tstart), .desc_tlen(desc_tlen), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .fifo_count(fifo_count), .busy(busy)
  );

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_vld_f = 1'b0; m_vld_p = 1'b0; m_vld_a = 1'b0;
  endfunction

  // Reference: five words per pulse, minus any FREQ/PHASE/AMP repeating the last one sent
  function automatic void model_push(logic [27:0] f, logic [15:0] p, logic [15:0] a,
                                     logic [27:0] ts, logic [23:0] tl);
    if (!(DEDUP && m_vld_f && m_freq == f))  exp_q.push_back({4'h1, f});
    if (!(DEDUP && m_vld_p && m_phase == p)) exp_q.push_back({4'h2, 12'h000, p});
    if (!(DEDUP && m_vld_a && m_amp == a))   exp_q.push_back({4'h3, 12'h000, a});
    exp_q.push_back({4'h4, ts});
    exp_q.push_back({4'h5, 4'h0, tl});
    m_freq = f; m_phase = p; m_amp = a;
    m_vld_f = 1'b1; m_vld_p = 1'b1; m_vld_a = 1'b1;
  endfunction

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_clear();
      end else begin
        if (inst_valid && inst_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_unexpected: got word %h, required no word", inst_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_word", inst_data, e);
            $display("inst word %08h expected %08h", inst_data, e);
          end
        end
        if (flush) model_clear();
        else if (desc_valid && desc_ready)
          model_push(desc_freq, desc_phase, desc_amp, desc_tstart, desc_tlen);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [27:0] f, input logic [15:0] p, input logic [15:0] a,
                      input logic [27:0] ts, input logic [23:0] tl);
    bit ok = 1'b0;
    desc_freq = f; desc_phase = p; desc_amp = a; desc_tstart = ts; desc_tlen = tl;
    desc_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (desc_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("push_timeout", {31'b0, desc_ready}, 32'd1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check(name, {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    logic r;
    r = inst_ready;
    inst_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    inst_ready = r;
  endtask

  task automatic wait_opcode(input logic [3:0] op, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (inst_valid && inst_data[31:28] == op) begin ok = 1'b1; break; end
    end
  endtask

  initial begin : main
    logic [31:0] t1_exp [5];
    bit          ok;
    int          base;
    t1_exp = '{32'h10ABCDEF, 32'h20001234, 32'h30007FFF, 32'h400003E8, 32'h50000040};

    @(posedge clk); #1;
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_desc_ready", {31'b0, desc_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single descriptor, exact cycle timing
    inst_ready = 1'b1;
    push(28'h0ABCDEF, 16'h1234, 16'h7FFF, 28'd1000, 24'd64);
    @(negedge clk);
    check("t1_latency_valid", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_word", inst_data, t1_exp[i]);
      check("t1_valid", {31'b0, inst_valid}, 32'd1);
    end
    @(negedge clk);
    check("t1_idle_valid", {31'b0, inst_valid}, 32'd0);
    check("t1_idle_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // backpressure on PHASE
    do_flush();
    inst_ready = 1'b0;
    push(28'h0ABCDEF, 16'h1234, 16'h7FFF, 28'd2000, 24'd8);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t2_stall_data", inst_data, 32'h20001234);
      check("t2_stall_valid", {31'b0, inst_valid}, 32'd1);
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    wait_idle("t2_idle");

    // fill the FIFO, then drain with no bubbles
    do_flush();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push($urandom, 16'h1000 + 16'(i), 16'h2000 + 16'(i), $urandom, 24'($urandom));
    @(negedge clk);
    check("t3_desc_ready", {31'b0, desc_ready}, 32'd0);
    check("t3_count", 32'(fifo_count), 32'd4);
    @(posedge clk); #1;
    desc_valid = 1'b1;
    desc_freq = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_5th_ready", {31'b0, desc_ready}, 32'd0);
    end
    check("t3_5th_count", 32'(fifo_count), 32'd4);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_no_bubble", {31'b0, inst_valid}, 32'd1);
    end
    @(negedge clk);
    check("t3_drained_valid", {31'b0, inst_valid}, 32'd0);
    check("t3_drained_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;

    // flush mid-AMP with two more queued, push discarded in the flush cycle
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(28'h0300000 + 28'(i), 16'h3100 + 16'(i), 16'h3200 + 16'(i), $urandom, 24'($urandom));
    inst_ready = 1'b1;
    wait_opcode(4'h3, ok);
    inst_ready = 1'b0;
    check("t4_reached_amp", {31'b0, ok}, 32'd1);
    desc_valid = 1'b1;
    desc_freq = 28'h0DEAD00;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    desc_valid = 1'b0;
    @(negedge clk);
    check("t4_flush_valid", {31'b0, inst_valid}, 32'd0);
    check("t4_flush_count", 32'(fifo_count), 32'd0);
    check("t4_flush_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    push(28'h0440044, 16'h4401, 16'h4402, 28'd4400, 24'd44);
    @(negedge clk);
    @(negedge clk);
    check("t4_restart_freq", inst_data, 32'h10440044);
    wait_idle("t4_idle");

    // asynchronous reset during TSTART
    push(28'h0550055, 16'h5501, 16'h5502, 28'd5500, 24'd55);
    wait_opcode(4'h4, ok);
    inst_ready = 1'b0;
    check("t5_reached_tstart", {31'b0, ok}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, inst_valid}, 32'd0);
    check("t5_rst_data", inst_data, 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_desc_ready", {31'b0, desc_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random stream with random backpressure and a small value pool
    drv_done = 1'b0;
    fork
      begin : rdy_proc
        while (!drv_done) begin
          @(posedge clk); #1;
          inst_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin : drv_proc
        for (int n = 0; n < 25; n++) begin
          for (int g = $urandom_range(0, 3); g > 0; g--) begin
            @(posedge clk); #1;
          end
          push($urandom_range(0, 1) ? 28'h0000111 : 28'h0000222,
               $urandom_range(0, 1) ? 16'h0001 : 16'h0002,
               $urandom_range(0, 1) ? 16'h0003 : 16'h0004,
               $urandom, 24'($urandom));
        end
        drv_done = 1'b1;
      end
    join
    inst_ready = 1'b1;
    wait_idle("t6_idle");

    // repeated freq/phase/amp, then again after a flush
    do_flush();
    inst_ready = 1'b1;
    base = hs_count;
    push(28'h0777777, 16'h7701, 16'h7702, 28'd7000, 24'd70);
    push(28'h0777777, 16'h7701, 16'h7702, 28'd7100, 24'd71);
    wait_idle("t7_idle_pair");
    check("t7_words_pair", 32'(hs_count - base), DEDUP ? 32'd7 : 32'd10);
    do_flush();
    base = hs_count;
    push(28'h0777777, 16'h7701, 16'h7702, 28'd7200, 24'd72);
    wait_idle("t7_idle_after_flush");
    check("t7_words_after_flush", 32'(hs_count - base), 32'd5);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
